pre_writeback: RTL

Post-result engine that consumes 512-bit convolution beats from the CCM over the PRE_TAKE handshake. For each beat it applies a right-shift, ReLU and 16-bit saturation to the 16 lanes, and packs the results into 8 words. It then writes the words to memory through its MemoryControl client port as one 8-word burst, stepping the write address for every beat. It is the receiving end of the CCM output stream and the PRE client of the memory arbiter.

---
 rtl/pre_pkg.sv | 20 ++
 rtl/pre_lane_sat.sv | 27 ++
 rtl/pre_writeback.sv | 100 ++++++++++
 3 files changed

// File: rtl/pre_pkg.sv
// pre_writeback shared types and constants.
// Memory command codes are common to all arbiter clients.
package pre_pkg;

  localparam logic [3:0] MEM_CMD_IDLE      = 4'd0;
  localparam logic [3:0] MEM_CMD_BURST_WR8 = 4'd2;

  localparam int unsigned LANES       = 16;
  localparam int unsigned WORDS       = 8;
  localparam int unsigned BURST_BYTES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WAIT_BEAT,
    ST_LOAD,
    ST_REQ
  } pre_state_t;

endpackage

// File: rtl/pre_lane_sat.sv
// One output lane: arithmetic shift, then ReLU or
// signed clamp into 16 bits.
module pre_lane_sat #(
  parameter int unsigned OUT_SHIFT = 0,
  parameter bit          RELU_EN   = 1'b1
) (
  input  logic [31:0] lane,
  output logic [15:0] res
);

  logic signed [31:0] y;

  assign y = $signed(lane) >>> OUT_SHIFT;

  always_comb begin
    res = y[15:0];
    if (y < 0) begin
      if (RELU_EN)
        res = '0;
      else if (y < -32768)
        res = 16'h8000;
    end else if (y > 32767) begin
      res = 16'h7FFF;
    end
  end

endmodule

// File: rtl/pre_writeback.sv
// Post-result engine: takes CCM beats, saturates lanes,
// streams 8 words into the write buffer and bursts them.
module pre_writeback
  import pre_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0,
  parameter bit          RELU_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PRE_START,
  output logic         PRE_STATUS,
  input  logic [31:0]  CFG_WRITE_START_ADDR,
  input  logic [15:0]  CFG_NUM_BEATS,
  input  logic [511:0] MAC_OUT,
  input  logic         PRE_TAKE_VLD,
  output logic         PRE_TAKE_RDY,
  output logic         PRE_REQ,
  output logic [31:0]  PRE_ADDR,
  output logic [3:0]   PRE_CMD,
  output logic         PRE_WR_BUF,
  output logic [31:0]  PRE_DIN,
  input  logic         MEM_PRE_SEL,
  input  logic         MEM_FIN
);

  pre_state_t state;
  logic [31:0] addr;
  logic [15:0] beats;
  logic [2:0]  k;
  logic [31:0] buf_q [WORDS];
  logic [LANES*16-1:0] proc;
  logic take;
  logic fin;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pre_lane_sat #(
      .OUT_SHIFT(OUT_SHIFT),
      .RELU_EN  (RELU_EN)
    ) u_sat (
      .lane(MAC_OUT[32*i +: 32]),
      .res (proc[16*i +: 16])
    );
  end

  assign take = (state == ST_WAIT_BEAT) && PRE_TAKE_VLD;
  assign fin  = MEM_PRE_SEL && MEM_FIN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      addr  <= '0;
      beats <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (PRE_START) begin
          addr  <= CFG_WRITE_START_ADDR;
          beats <= CFG_NUM_BEATS;
          state <= ST_CFG;
        end
        ST_CFG:
          state <= (beats == '0) ? ST_IDLE : ST_WAIT_BEAT;
        ST_WAIT_BEAT: if (take) begin
          k     <= '0;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          k <= k + 3'd1;
          if (k == 3'd7)
            state <= ST_REQ;
        end
        ST_REQ: if (fin) begin
          addr  <= addr + 32'(BURST_BYTES);
          beats <= beats - 16'd1;
          state <= (beats == 16'd1) ? ST_IDLE : ST_WAIT_BEAT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data capture needs no reset: only read while in LOAD.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int w = 0; w < WORDS; w++)
        buf_q[w] <= proc[32*w +: 32];
    end
  end

  assign PRE_STATUS   = (state != ST_IDLE);
  assign PRE_TAKE_RDY = take;
  assign PRE_REQ      = (state == ST_REQ);
  assign PRE_CMD      = PRE_REQ ? MEM_CMD_BURST_WR8
                                : MEM_CMD_IDLE;
  assign PRE_ADDR     = addr;
  assign PRE_WR_BUF   = (state == ST_LOAD);
  assign PRE_DIN      = PRE_WR_BUF ? buf_q[k] : '0;

endmodule
